// File: rtl/sat_add_pkg.sv
// -----------------------------------------------------------------------------
// sat_add_pkg
// Shared definitions for the signed saturating adder.
//   DEFAULT_WIDTH : default operand/result width in bits.
//   satMax(w)     : largest result code, 2^(w-1)-1.
//   satMin(w)     : smallest result code, -satMax(w). The range is symmetric,
//                   so the most-negative two's-complement code never appears
//                   on the output.
// Optional feature macro (consumed by the other files): SAT_ADD_FLAG_EN.
// -----------------------------------------------------------------------------
package sat_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int satMax(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int satMin(input int width);
    return -satMax(width);
  endfunction

endpackage

// File: rtl/sat_add_if.sv
// -----------------------------------------------------------------------------
// sat_add_if
// Operand/result bundle for sat_add.
//   in_valid  : operands a/b are valid this cycle (master -> slave)
//   a, b      : signed operands, WIDTH bits (master -> slave)
//   o         : signed saturated sum, registered (slave -> master)
//   out_valid : o is valid, registered copy of in_valid (slave -> master)
//   sat       : registered sum was clamped (slave -> master), only present
//               when SAT_ADD_FLAG_EN is defined
// Modports: master (operand source), slave (the adder).
// -----------------------------------------------------------------------------
interface sat_add_if
  import sat_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                    in_valid;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic signed [WIDTH-1:0] o;
  logic                    out_valid;

`ifdef SAT_ADD_FLAG_EN
  logic sat;

  modport master (output in_valid, a, b, input o, out_valid, sat);
  modport slave  (input in_valid, a, b, output o, out_valid, sat);
`else
  modport master (output in_valid, a, b, input o, out_valid);
  modport slave  (input in_valid, a, b, output o, out_valid);
`endif

endinterface

// File: rtl/sat_clamp.sv
// -----------------------------------------------------------------------------
// sat_clamp
// Combinational symmetric clamp of a full-precision signed sum.
//   sum_i     : (WIDTH+1)-bit signed sum
//   val_o     : WIDTH-bit signed value clamped to [satMin, satMax]
//   clamped_o : high when clamping changed the value
// -----------------------------------------------------------------------------
module sat_clamp
  import sat_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH:0]   sum_i,
  output logic signed [WIDTH-1:0] val_o,
  output logic                    clamped_o
);

  // Limits held at sum width so the comparisons stay signed and full precision.
  localparam int MAX_I = satMax(WIDTH);
  localparam int MIN_I = satMin(WIDTH);
  localparam logic signed [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_I);
  localparam logic signed [WIDTH:0] MIN_EXT = (WIDTH+1)'(MIN_I);

  // In-range sums fit in WIDTH bits, so dropping the top bit is lossless there.
  // The lower bound is -MAX, which also folds the most-negative code onto MIN.
  always_comb begin
    val_o     = sum_i[WIDTH-1:0];
    clamped_o = 1'b0;
    if (sum_i > MAX_EXT) begin
      val_o     = MAX_EXT[WIDTH-1:0];
      clamped_o = 1'b1;
    end else if (sum_i < MIN_EXT) begin
      val_o     = MIN_EXT[WIDTH-1:0];
      clamped_o = 1'b1;
    end
  end

endmodule

// File: rtl/sat_add.sv
// -----------------------------------------------------------------------------
// sat_add
// Signed saturating adder with a one-cycle registered result, used for
// fixed-point accumulation in the MNIST inference datapath.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears o, out_valid and sat
//   bus   : sat_add_if.slave (in_valid, a, b in; o, out_valid, sat out)
// Result o = clamp(a + b, -(2^(WIDTH-1)-1), 2^(WIDTH-1)-1), captured on the
// edge where in_valid is high; o/sat hold otherwise, out_valid follows in_valid.
// Macro SAT_ADD_FLAG_EN adds the registered sat flag; without it the flag
// register and port are absent and everything else is identical.
// -----------------------------------------------------------------------------
module sat_add
  import sat_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  sat_add_if.slave bus
);

  logic signed [WIDTH:0]   sumFull;
  logic signed [WIDTH-1:0] clampVal;
  logic signed [WIDTH-1:0] result_q;
  logic signed [WIDTH-1:0] result_d;
  logic                    valid_q;

  // One extra bit of headroom makes the sum exact for every operand pair,
  // including the most-negative code.
  assign sumFull = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};

`ifdef SAT_ADD_FLAG_EN
  logic clampFlag;
  logic sat_q;
  logic sat_d;

  sat_clamp #(.WIDTH(WIDTH)) u_clamp (
    .sum_i     (sumFull),
    .val_o     (clampVal),
    .clamped_o (clampFlag)
  );
`else
  // Flag has no consumer when the sat port is compiled out.
  logic unusedClamp;

  sat_clamp #(.WIDTH(WIDTH)) u_clamp (
    .sum_i     (sumFull),
    .val_o     (clampVal),
    .clamped_o (unusedClamp)
  );
`endif

  // Result (and flag) only move on a valid beat so o holds across idle cycles.
  always_comb begin
    result_d = result_q;
    if (bus.in_valid) begin
      result_d = clampVal;
    end
  end

`ifdef SAT_ADD_FLAG_EN
  always_comb begin
    sat_d = sat_q;
    if (bus.in_valid) begin
      sat_d = clampFlag;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= bus.in_valid;
    end
  end

`ifdef SAT_ADD_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign bus.sat = sat_q;
`endif

  assign bus.o         = result_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_sat_add.sv
// -----------------------------------------------------------------------------
// tb_sat_add
// Scoreboard bench for sat_add at WIDTH=4 and WIDTH=8. The driver pushes the
// expected per-cycle response for each DUT into a queue; one monitor per DUT
// pops and compares shortly after each rising edge. Expected values come from
// a plain integer clamp model. sat is checked when SAT_ADD_FLAG_EN is defined.
// -----------------------------------------------------------------------------
module tb_sat_add;

  logic clk;
  logic rst_n;

  sat_add_if #(.WIDTH(4)) bus4 ();
  sat_add_if #(.WIDTH(8)) bus8 ();

  sat_add #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  sat_add #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int o;
    bit sat;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4;
  exp_t e8;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: what each DUT should be holding on its outputs.
  int last4O   = 0;
  bit last4Sat = 1'b0;
  int last8O   = 0;
  bit last8Sat = 1'b0;

  // Reference: exact integer sum clamped to the symmetric range of width w.
  function automatic int clampRef(input int s, input int w);
    int m;
    m = (1 << (w - 1)) - 1;
    if (s > m) return m;
    if (s < -m) return -m;
    return s;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle on the chosen DUT (the other one idles) and queues the
  // response expected one edge later.
  task automatic applyStimulus(input int w, input bit v, input int av, input int bv);
    exp_t e;
    int   r;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    r = clampRef(av + bv, w);
    if (w == 4) begin
      bus4.in_valid = v;
      bus4.a        = 4'(av);
      bus4.b        = 4'(bv);
      if (v) begin
        last4O   = r;
        last4Sat = (r != av + bv);
      end
      e.valid = v;
      e.o     = last4O;
      e.sat   = last4Sat;
      q4.push_back(e);
    end else begin
      bus8.in_valid = v;
      bus8.a        = 8'(av);
      bus8.b        = 8'(bv);
      if (v) begin
        last8O   = r;
        last8Sat = (r != av + bv);
      end
      e.valid = v;
      e.o     = last8O;
      e.sat   = last8Sat;
      q8.push_back(e);
    end
  endtask

  // Monitor for the WIDTH=4 instance.
  always @(posedge clk) begin
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      checkOutput("w4 out_valid", int'(bus4.out_valid), int'(e4.valid));
      checkOutput("w4 o", int'(bus4.o), e4.o);
`ifdef SAT_ADD_FLAG_EN
      checkOutput("w4 sat", int'(bus4.sat), int'(e4.sat));
`endif
    end else if (bus4.out_valid) begin
      checkOutput("w4 unexpected out_valid", int'(bus4.out_valid), 0);
    end
  end

  // Monitor for the WIDTH=8 instance.
  always @(posedge clk) begin
    #1;
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      checkOutput("w8 out_valid", int'(bus8.out_valid), int'(e8.valid));
      checkOutput("w8 o", int'(bus8.o), e8.o);
`ifdef SAT_ADD_FLAG_EN
      checkOutput("w8 sat", int'(bus8.sat), int'(e8.sat));
`endif
    end else if (bus8.out_valid) begin
      checkOutput("w8 unexpected out_valid", int'(bus8.out_valid), 0);
    end
  end

  initial begin
    bus4.in_valid = 1'b0;
    bus4.a        = '0;
    bus4.b        = '0;
    bus8.in_valid = 1'b0;
    bus8.a        = '0;
    bus8.b        = '0;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state before any clocking.
    #11;
    checkOutput("reset w4 o", int'(bus4.o), 0);
    checkOutput("reset w4 out_valid", int'(bus4.out_valid), 0);
    checkOutput("reset w8 o", int'(bus8.o), 0);
    checkOutput("reset w8 out_valid", int'(bus8.out_valid), 0);
`ifdef SAT_ADD_FLAG_EN
    checkOutput("reset w4 sat", int'(bus4.sat), 0);
`endif
    #1 rst_n = 1'b1;

    // Spot values, most-negative code and saturation-flag boundaries.
    applyStimulus(4, 1'b1, 3, 2);
    applyStimulus(4, 1'b1, 7, 1);
    applyStimulus(4, 1'b1, -7, -7);
    applyStimulus(4, 1'b1, 5, -6);
    applyStimulus(4, 1'b1, -8, 0);
    applyStimulus(4, 1'b1, -8, 7);
    applyStimulus(4, 1'b1, -8, -8);
    applyStimulus(4, 1'b1, 4, 3);
    applyStimulus(4, 1'b1, 4, 4);
    applyStimulus(4, 1'b1, -4, -4);

    // Exhaustive sweep over the symmetric operand range.
    for (int ia = -7; ia <= 7; ia++) begin
      for (int ib = -7; ib <= 7; ib++) begin
        applyStimulus(4, 1'b1, ia, ib);
      end
    end

    // Valid pipeline pattern 1,0,1,1 (o must hold through the idle beat).
    applyStimulus(4, 1'b1, 3, 2);
    applyStimulus(4, 1'b0, 1, 1);
    applyStimulus(4, 1'b1, -2, -3);
    applyStimulus(4, 1'b1, 6, 6);

    // Random operands over the full code range with random valid.
    repeat (200) begin
      applyStimulus(4, 1'($urandom_range(1)),
                    int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
    end

    // Asynchronous reset in the middle of a cycle while o = 5.
    applyStimulus(4, 1'b1, 3, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset o", int'(bus4.o), 0);
    checkOutput("async reset out_valid", int'(bus4.out_valid), 0);
`ifdef SAT_ADD_FLAG_EN
    checkOutput("async reset sat", int'(bus4.sat), 0);
`endif
    // Operands presented during reset must not be captured.
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.a        = 4'(6);
    bus4.b        = 4'(1);
    @(posedge clk);
    #1;
    checkOutput("in reset o", int'(bus4.o), 0);
    checkOutput("in reset out_valid", int'(bus4.out_valid), 0);
    last4O   = 0;
    last4Sat = 1'b0;
    last8O   = 0;
    last8Sat = 1'b0;
    #1 rst_n = 1'b1;
    applyStimulus(4, 1'b1, 2, 2);
    applyStimulus(4, 1'b0, 0, 0);

    // WIDTH=8 instance.
    applyStimulus(8, 1'b1, 100, 100);
    applyStimulus(8, 1'b1, -100, -100);
    applyStimulus(8, 1'b1, -128, 0);
    applyStimulus(8, 1'b1, 127, 0);
    applyStimulus(8, 1'b1, -127, 0);
    applyStimulus(8, 1'b1, 64, 63);
    repeat (150) begin
      applyStimulus(8, 1'($urandom_range(1)),
                    int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    end

    // Let the monitors drain; anything left means a lost response.
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard drain", int'(q4.size() + q8.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
